// File: rtl/guess_scorer_if.sv
// Request/result bundle between a game controller and the guess scorer.
// The master drives the request; the slave (the scorer) returns the result.
interface guess_scorer_if;
    logic        START;
    logic        ABORT;
    logic [15:0] SECRET;
    logic [15:0] GUESS;
    logic        BUSY;
    logic        DONE;
    logic [2:0]  EXACT;
    logic [2:0]  MISPLACED;
    logic        MATCH;

    modport master (
        output START, ABORT, SECRET, GUESS,
        input  BUSY, DONE, EXACT, MISPLACED, MATCH
    );

    modport slave (
        input  START, ABORT, SECRET, GUESS,
        output BUSY, DONE, EXACT, MISPLACED, MATCH
    );
endinterface

// File: rtl/guess_scorer.sv
// Sequential Mastermind-style scorer: 4 exact-position cycles, then 16 pairwise
// misplaced-digit cycles, then a one-cycle DONE with the registered result.
module guess_scorer (
    input  logic          DIV_CLOCK,
    input  logic          RST,
    guess_scorer_if.slave bus
);

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned CODE_W = NIB_W * DIGITS;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned IDX_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXACT,
        S_MISP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   secret_q, secret_d;
    logic [CODE_W-1:0]   guess_q, guess_d;
    logic [DIGITS-1:0]   s_used_q, s_used_d;
    logic [DIGITS-1:0]   g_used_q, g_used_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    exact_cnt_q, exact_cnt_d;
    logic [CNT_W-1:0]    misp_cnt_q, misp_cnt_d;
    logic [CNT_W-1:0]    exact_q, exact_d;
    logic [CNT_W-1:0]    misp_q, misp_d;
    logic                match_q, match_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Secret digit is always idx[1:0]; guess digit is idx[1:0] in EXACT, idx[3:2] in MISP.
    logic [1:0]          s_sel_c, g_sel_c;
    logic [NIB_W-1:0]    sec_nib_c, gss_nib_c;
    logic                digit_eq_c;

    assign s_sel_c    = idx_q[1:0];
    assign g_sel_c    = (state_q == S_MISP) ? idx_q[3:2] : idx_q[1:0];
    assign sec_nib_c  = secret_q[{s_sel_c, 2'b00} +: NIB_W];
    assign gss_nib_c  = guess_q[{g_sel_c, 2'b00} +: NIB_W];
    assign digit_eq_c = (sec_nib_c == gss_nib_c);

    always_comb begin
        state_d     = state_q;
        secret_d    = secret_q;
        guess_d     = guess_q;
        s_used_d    = s_used_q;
        g_used_d    = g_used_q;
        idx_d       = idx_q;
        exact_cnt_d = exact_cnt_q;
        misp_cnt_d  = misp_cnt_q;
        exact_d     = exact_q;
        misp_d      = misp_q;
        match_d     = match_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (bus.ABORT) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                // The DONE->IDLE edge doubles as the first IDLE sampling edge,
                // giving one result every 21 cycles with START held high.
                S_IDLE, S_DONE: begin
                    if (bus.START) begin
                        state_d     = S_EXACT;
                        secret_d    = bus.SECRET;
                        guess_d     = bus.GUESS;
                        s_used_d    = '0;
                        g_used_d    = '0;
                        idx_d       = '0;
                        exact_cnt_d = '0;
                        misp_cnt_d  = '0;
                        busy_d      = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
                S_EXACT: begin
                    if (digit_eq_c) begin
                        exact_cnt_d       = exact_cnt_q + CNT_W'(1);
                        s_used_d[s_sel_c] = 1'b1;
                        g_used_d[g_sel_c] = 1'b1;
                    end
                    if (idx_q[1:0] == 2'd3) begin
                        idx_d   = '0;
                        state_d = S_MISP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                S_MISP: begin
                    if (digit_eq_c && !g_used_q[g_sel_c] && !s_used_q[s_sel_c]) begin
                        misp_cnt_d        = misp_cnt_q + CNT_W'(1);
                        s_used_d[s_sel_c] = 1'b1;
                        g_used_d[g_sel_c] = 1'b1;
                    end
                    if (idx_q == IDX_W'(DIGITS * DIGITS - 1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        exact_d = exact_cnt_q;
                        misp_d  = misp_cnt_d;
                        match_d = (exact_cnt_q == CNT_W'(DIGITS));
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge DIV_CLOCK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            secret_q    <= '0;
            guess_q     <= '0;
            s_used_q    <= '0;
            g_used_q    <= '0;
            idx_q       <= '0;
            exact_cnt_q <= '0;
            misp_cnt_q  <= '0;
            exact_q     <= '0;
            misp_q      <= '0;
            match_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            secret_q    <= secret_d;
            guess_q     <= guess_d;
            s_used_q    <= s_used_d;
            g_used_q    <= g_used_d;
            idx_q       <= idx_d;
            exact_cnt_q <= exact_cnt_d;
            misp_cnt_q  <= misp_cnt_d;
            exact_q     <= exact_d;
            misp_q      <= misp_d;
            match_q     <= match_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.EXACT     = exact_q;
    assign bus.MISPLACED = misp_q;
    assign bus.MATCH     = match_q;

endmodule

// File: tb/tb_guess_scorer.sv
// Bench for guess_scorer: directed and random scoring against a digit-count
// reference model, plus latency, back-to-back, abort and reset scenarios.
module tb_guess_scorer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   prev_e;
    int   prev_m;
    int   prev_x;

    guess_scorer_if bus ();

    guess_scorer dut (
        .DIV_CLOCK (clk),
        .RST       (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Exact = same value at same position; misplaced = per-value overlap of the leftovers.
    function automatic void score_model(input logic [15:0] s, input logic [15:0] g,
                                        output int e, output int m);
        int cs [16];
        int cg [16];
        logic [3:0] sd;
        logic [3:0] gd;
        for (int v = 0; v < 16; v++) begin
            cs[v] = 0;
            cg[v] = 0;
        end
        e = 0;
        m = 0;
        for (int k = 0; k < 4; k++) begin
            sd = s[4*k +: 4];
            gd = g[4*k +: 4];
            if (sd == gd) e++;
            else begin
                cs[sd]++;
                cg[gd]++;
            end
        end
        for (int v = 0; v < 16; v++) m += (cs[v] < cg[v]) ? cs[v] : cg[v];
    endfunction

    task automatic run_one(input logic [15:0] s, input logic [15:0] g,
                           input int exp_e, input int exp_m, input string tag);
        int lat;
        int hold_bad;
        bus.SECRET = s;
        bus.GUESS  = g;
        bus.START  = 1'b1;
        tick;
        bus.START  = 1'b0;
        bus.SECRET = 16'($urandom);
        bus.GUESS  = 16'($urandom);
        check_eq({tag, "_busy_acc"}, int'(bus.BUSY), 1);
        lat = -1;
        hold_bad = 0;
        for (int c = 1; c <= 40; c++) begin
            tick;
            if (bus.DONE) begin
                lat = c;
                break;
            end
            if (int'(bus.EXACT) != prev_e || int'(bus.MISPLACED) != prev_m ||
                int'(bus.MATCH) != prev_x)
                hold_bad = 1;
        end
        check_eq({tag, "_latency"}, lat, 20);
        check_eq({tag, "_hold"}, hold_bad, 0);
        check_eq({tag, "_busy_done"}, int'(bus.BUSY), 1);
        check_eq({tag, "_exact"}, int'(bus.EXACT), exp_e);
        check_eq({tag, "_misp"}, int'(bus.MISPLACED), exp_m);
        check_eq({tag, "_match"}, int'(bus.MATCH), (exp_e == 4) ? 1 : 0);
        tick;
        check_eq({tag, "_done_pulse"}, int'(bus.DONE), 0);
        check_eq({tag, "_busy_end"}, int'(bus.BUSY), 0);
        prev_e = exp_e;
        prev_m = exp_m;
        prev_x = (exp_e == 4) ? 1 : 0;
    endtask

    initial begin
        logic [15:0] rs;
        logic [15:0] rg;
        int e;
        int m;
        int npulse;
        int last;
        int gap_bad;
        int idle_seen;

        n_checks = 0;
        n_fail   = 0;
        prev_e   = 0;
        prev_m   = 0;
        prev_x   = 0;
        rst        = 1'b1;
        bus.START  = 1'b0;
        bus.ABORT  = 1'b0;
        bus.SECRET = '0;
        bus.GUESS  = '0;
        #1;
        check_eq("rst_busy", int'(bus.BUSY), 0);
        check_eq("rst_done", int'(bus.DONE), 0);
        check_eq("rst_exact", int'(bus.EXACT), 0);
        check_eq("rst_misp", int'(bus.MISPLACED), 0);
        check_eq("rst_match", int'(bus.MATCH), 0);
        #11;
        rst = 1'b0;
        tick;

        run_one(16'h1234, 16'h1234, 4, 0, "all_exact");
        run_one(16'h1234, 16'h4321, 0, 4, "all_misp");
        run_one(16'h1123, 16'h3111, 1, 2, "dup_a");
        run_one(16'hAAAA, 16'hA000, 1, 0, "dup_b");

        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < 4; k++) begin
                rs[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3))
                                                           : 4'($urandom_range(0, 15));
                rg[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3))
                                                           : 4'($urandom_range(0, 15));
            end
            score_model(rs, rg, e, m);
            run_one(rs, rg, e, m, "rand");
        end

        // START held high: accepts at edges 0, 21, 42, ... with DONE 20 cycles after each.
        bus.SECRET = 16'h1234;
        bus.GUESS  = 16'h0000;
        bus.START  = 1'b1;
        tick;
        npulse  = 0;
        last    = -1;
        gap_bad = 0;
        for (int c = 1; c <= 63; c++) begin
            if (c == 5) begin
                bus.SECRET = 16'h0000;
                bus.GUESS  = 16'h0000;
            end
            if (c == 15) begin
                bus.SECRET = 16'h1234;
                bus.GUESS  = 16'h0000;
            end
            tick;
            if (bus.DONE) begin
                if (last >= 0 && c - last != 21) gap_bad = 1;
                npulse++;
                last = c;
                check_eq("held_exact", int'(bus.EXACT), 0);
                check_eq("held_misp", int'(bus.MISPLACED), 0);
            end
        end
        check_eq("held_pulses", npulse, 3);
        check_eq("held_gap", gap_bad, 0);
        check_eq("held_last", last, 62);
        bus.START = 1'b0;
        idle_seen = 0;
        for (int c = 0; c < 30; c++) begin
            tick;
            if (!bus.BUSY) begin
                idle_seen = 1;
                break;
            end
        end
        check_eq("held_drain", idle_seen, 1);
        prev_e = 0;
        prev_m = 0;
        prev_x = 0;

        run_one(16'h1234, 16'h1243, 2, 2, "pre_abort");

        // Abort 10 cycles after acceptance.
        bus.SECRET = 16'h5678;
        bus.GUESS  = 16'h5678;
        bus.START  = 1'b1;
        tick;
        bus.START = 1'b0;
        repeat (9) tick;
        bus.ABORT = 1'b1;
        tick;
        bus.ABORT = 1'b0;
        check_eq("abort_busy", int'(bus.BUSY), 0);
        npulse = 0;
        for (int c = 0; c < 30; c++) begin
            tick;
            if (bus.DONE) npulse++;
        end
        check_eq("abort_no_done", npulse, 0);
        check_eq("abort_exact", int'(bus.EXACT), prev_e);
        check_eq("abort_misp", int'(bus.MISPLACED), prev_m);
        check_eq("abort_match", int'(bus.MATCH), prev_x);
        bus.ABORT = 1'b1;
        bus.START = 1'b1;
        tick;
        check_eq("abort_start_busy", int'(bus.BUSY), 0);
        bus.ABORT = 1'b0;
        bus.START = 1'b0;
        tick;
        check_eq("abort_start_idle", int'(bus.BUSY), 0);

        // Reset five cycles into the misplaced phase.
        bus.SECRET = 16'h1111;
        bus.GUESS  = 16'h1111;
        bus.START  = 1'b1;
        tick;
        bus.START = 1'b0;
        repeat (9) tick;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", int'(bus.BUSY), 0);
        check_eq("mid_rst_done", int'(bus.DONE), 0);
        check_eq("mid_rst_exact", int'(bus.EXACT), 0);
        check_eq("mid_rst_misp", int'(bus.MISPLACED), 0);
        check_eq("mid_rst_match", int'(bus.MATCH), 0);
        tick;
        tick;
        #3;
        rst = 1'b0;
        npulse = 0;
        for (int c = 0; c < 25; c++) begin
            tick;
            if (bus.DONE) npulse++;
        end
        check_eq("post_rst_no_done", npulse, 0);
        prev_e = 0;
        prev_m = 0;
        prev_x = 0;
        run_one(16'hBEEF, 16'hFEEB, 2, 2, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/guess_scorer.md
GUESS_SCORER -- requirements
Module: guess_scorer

Interface
REQ-001 Parameters: none; digit count fixed at 4 hex nibbles, nibble 0 = bits [3:0].
REQ-002 DIV_CLOCK  input  1  divided game clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 START  input  1  request to score; sampled high on a DIV_CLOCK edge while idle.
REQ-005 ABORT  input  1  synchronous cancel of any operation (AI-reveal / round abandon).
REQ-006 SECRET  input  16  code being guessed, four 4-bit digits.
REQ-007 GUESS  input  16  player guess, four 4-bit digits.
REQ-008 BUSY  output  1  high while an operation is in progress (states EXACT, MISP, DONE).
REQ-009 DONE  output  1  one-cycle pulse; result outputs valid and updated in this cycle.
REQ-010 EXACT  output  3  count of digits correct in value and position, 0..4.
REQ-011 MISPLACED  output  3  count of digits correct in value, wrong position, 0..4.
REQ-012 MATCH  output  1  high when EXACT == 4.

Function
REQ-013 FSM states IDLE, EXACT, MISP, DONE; encoding free.
REQ-014 IDLE: START=1 and ABORT=0 at an edge -> latch SECRET and GUESS into internal copies, clear working counters and both 4-bit used masks, go EXACT.
REQ-015 SECRET/GUESS input changes after acceptance have no effect on the running operation.
REQ-016 EXACT: 4 cycles, index k = 0..3, one per cycle; if secret[k] == guess[k], increment exact counter, set secret_used[k] and guess_used[k]; after k = 3 go MISP.
REQ-017 MISP: exactly 16 cycles, outer guess index i = 0..3, inner secret index j = 0..3, one (i,j) pair per cycle.
REQ-018 MISP pair rule: if !guess_used[i], !secret_used[j] and guess[i] == secret[j], increment misplaced counter, set guess_used[i] and secret_used[j].
REQ-019 Each secret digit and each guess digit contributes to at most one count total; duplicates never double-count.
REQ-020 After pair (3,3) go DONE; in DONE, DONE=1, EXACT/MISPLACED/MATCH take working counter values in the same cycle; next edge -> IDLE.
REQ-021 Latency fixed: START accepted at edge N -> DONE high in the cycle following edge N+20, for 1 cycle; BUSY high from edge N to edge N+21.
REQ-022 Back-to-back: START may be accepted at edge N+21 (first IDLE edge); throughput 1 result per 21 cycles.
REQ-023 START while BUSY (any state including DONE) ignored; no queuing.
REQ-024 EXACT, MISPLACED, MATCH hold last completed result until the next DONE; unchanged during BUSY.
REQ-025 ABORT=1 at an edge in any state -> IDLE next cycle, no DONE pulse, result outputs unchanged; ABORT and START together in IDLE -> ABORT wins, nothing accepted.
REQ-026 Counters 3 bits, saturating impossible by construction (max 4); EXACT + MISPLACED <= 4 always.

Reset
REQ-027 RST asserted -> immediately IDLE; BUSY=0, DONE=0, EXACT=0, MISPLACED=0, MATCH=0; internal copies, masks, indices, counters cleared.
REQ-028 RST mid-operation aborts it; no DONE pulse after release; first START after release is accepted normally.

Verification
REQ-029 SECRET=0x1234, GUESS=0x1234, START pulse -> DONE 20 cycles after acceptance edge, EXACT=4, MISPLACED=0, MATCH=1.
REQ-030 SECRET=0x1234, GUESS=0x4321 -> EXACT=0, MISPLACED=4, MATCH=0.
REQ-031 Duplicates: SECRET=0x1123, GUESS=0x3111 -> EXACT=1, MISPLACED=2; SECRET=0xAAAA, GUESS=0xA000 -> EXACT=1, MISPLACED=0.
REQ-032 START held high continuously with SECRET=0x1234, GUESS=0x0000 -> one DONE every 21 cycles, EXACT=0, MISPLACED=0, no extra pulses; inputs changed mid-operation do not alter result.
REQ-033 ABORT at 10 cycles after acceptance -> BUSY=0 next cycle, no DONE, outputs keep prior result; ABORT+START same edge in IDLE -> BUSY stays 0.
REQ-034 RST asserted 5 cycles into MISP -> all outputs 0 asynchronously, BUSY=0; after release, SECRET=0xBEEF, GUESS=0xFEEB -> EXACT=2, MISPLACED=2.
